tdm_slot_arbiter: RTL
=====================

TDM_SLOT_ARBITER -- requirements
Module: tdm_slot_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters. The table and owner width are fixed at 2 bits for 4 requesters.
REQ-002 Parameter NUM_SLOTS, default 7: slots per frame. The slot index is 3 bits wide and runs 0..NUM_SLOTS-1.
REQ-003 Parameter HOLD_MAX, default 3: maximum number of consecutive grant cycles per slot, minimum 1.
REQ-004 clk  in  1: the single clock. All state updates on its rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 enable  in  1: when high, new grants are allowed and the slot counter advances.
REQ-007 req  in  NUM_REQ: per-requester request level.
REQ-008 cfg_we  in  1: slot-table write strobe.
REQ-009 cfg_slot  in  3: slot index to write.
REQ-010 cfg_owner  in  2: requester index to store in that slot.
REQ-011 gnt  out  NUM_REQ: registered grant, one-hot or zero.
REQ-012 slot  out  3: current slot index.
REQ-013 busy  out  1: high while in GRANT.
REQ-014 frame_start  out  1: one-cycle pulse when slot wraps from NUM_SLOTS-1 to 0.

Function
REQ-015 FSM has two states, IDLE and GRANT. Outputs are registered.
REQ-016 In IDLE with enable=1, owner = table[slot]:
  - if req[owner]=1: next edge gnt=onehot(owner), state GRANT, hold=1, slot unchanged.
  - otherwise: slot advances at that edge and gnt stays 0.
REQ-017 In GRANT, the grant is released at the edge where req[winner]=0 or hold==HOLD_MAX. On release: gnt=0, state IDLE, slot advances. Otherwise hold increments and gnt is unchanged.
REQ-018 Every grant is followed by at least one IDLE cycle with gnt=0.
REQ-019 Slot advance is slot+1, with NUM_SLOTS-1 wrapping to 0. frame_start=1 in the cycle after the wrap edge and 0 otherwise.
REQ-020 enable=0 in IDLE: no grant, slot frozen, frame_start=0.
REQ-021 enable=0 in GRANT: the grant completes per REQ-017, then the block holds in IDLE with the slot frozen.
REQ-022 A cfg_we write takes effect from the next cycle.
REQ-023 A write with cfg_slot >= NUM_SLOTS is ignored.
REQ-024 A write to the current slot during GRANT does not alter the active grant.
REQ-025 If cfg_we and an IDLE evaluation of the same slot occur in the same cycle, the evaluation uses the old table entry.
REQ-026 gnt never has more than one bit set, and busy equals |gnt.

Reset
REQ-027 On reset=1 at a clock edge:
  - state IDLE, gnt=0, slot=0, busy=0, frame_start=0, hold=0
  - table[i] = i mod NUM_REQ
  - round-robin pointer = 0
REQ-028 Reset asserted during GRANT drops gnt at that same edge. Reset overrides enable and cfg_we.

Configuration
REQ-029 Macro TDM_WORK_CONSERVING_EN, when defined: in IDLE with req[owner]=0, the block grants the first requesting index after rr_ptr in circular order. rr_ptr is set to the winner on every grant. The slot does not advance until that grant is released.
REQ-030 When TDM_WORK_CONSERVING_EN is undefined, non-owner requests are never granted, rr_ptr is absent, and REQ-016 applies unchanged.

Structure
REQ-031 Package tdm_pkg holds:
  - NUM_SLOTS and NUM_REQ defaults
  - slot_t (3-bit) and owner_t (2-bit) typedefs
  - the state enum {IDLE, GRANT}
REQ-032 Sub-module tdm_slot_counter implements the wrapping slot counter with an advance input and a frame_start output. Everything else, including table storage, is in tdm_slot_arbiter.

Verification
REQ-033 Scenario 1: reset, default table, enable=1, req=0001 held. Required response:
  - gnt=0001 for 3 cycles, then 0.
  - Slots 1, 2 and 3 are each skipped in one cycle.
  - At slot 4, gnt=0001 again.
  - frame_start pulses after slot 6.
REQ-034 Scenario 2: req[2] held, then dropped after 1 grant cycle. The grant lasts exactly 1 cycle and slot advances 2->3 at the release edge.
REQ-035 Scenario 3: write cfg_slot=1, cfg_owner=3, then cfg_slot=7, cfg_owner=0; req=1000. Required response:
  - Slots 1 and 3 grant requester 3.
  - The slot-7 write has no effect.
REQ-036 Scenario 4: reset asserted mid-GRANT. Next cycle: gnt=0, slot=0, table restored to defaults.
REQ-037 Scenario 5: enable dropped during GRANT at slot 2. The grant completes, then slot stays at 3 with gnt=0 until enable returns.
REQ-038 Scenario 6, with TDM_WORK_CONSERVING_EN defined: at slot 0, req=0110. Required response:
  - gnt=0010, then gnt=0100 at slot 1's owner-idle case only if req[1]=0.
  - Without the macro, req=0110 at slot 0 yields no grant and the slot advances.

Source files
------------

// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdm_pkg
// Description : Shared types and defaults for the TDM slot arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package tdm_pkg;

    localparam int TDM_NUM_SLOTS = 7;
    localparam int TDM_NUM_REQ   = 4;

    typedef logic [2:0] slot_t;
    typedef logic [1:0] owner_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tdm_slot_counter.sv
`default_nettype none
// ============================================================================
// Module      : tdm_slot_counter
// Description : Wrapping slot index with a one-cycle frame_start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int NUM_SLOTS = TDM_NUM_SLOTS
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  advance,
    output slot_t slot,
    output logic  frame_start
);

    localparam slot_t c_last_slot = slot_t'(NUM_SLOTS - 1);

    slot_t r_slot;
    logic  r_frame_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot        <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= advance && (r_slot == c_last_slot);
            if (advance) begin
                r_slot <= (r_slot == c_last_slot) ? '0 : r_slot + slot_t'(1);
            end
        end
    end

    assign slot        = r_slot;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: rtl/tdm_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tdm_slot_arbiter
// Description : TDM slot-table arbiter with bounded grant hold. Optional
//               work-conserving fallback enabled by TDM_WORK_CONSERVING_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_slot_arbiter
    import tdm_pkg::*;
#(
    parameter int NUM_REQ   = TDM_NUM_REQ,
    parameter int NUM_SLOTS = TDM_NUM_SLOTS,
    parameter int HOLD_MAX  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    input  logic               cfg_we,
    input  slot_t              cfg_slot,
    input  owner_t             cfg_owner,
    output logic [NUM_REQ-1:0] gnt,
    output slot_t              slot,
    output logic               busy,
    output logic               frame_start
);

    localparam int              c_hold_w   = $clog2(HOLD_MAX + 1);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(HOLD_MAX);

    state_t               r_state, w_state_nxt;
    logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;
    logic [c_hold_w-1:0]  r_hold, w_hold_nxt;
    owner_t               r_winner, w_winner_nxt;
    owner_t               r_table [NUM_SLOTS];
    owner_t               w_owner;
    logic                 w_advance;

    assign w_owner = r_table[slot];

    // Out-of-range slot indices match no entry, so such writes fall away.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (reset) begin
                r_table[i] <= owner_t'(i % NUM_REQ);
            end else if (cfg_we && (cfg_slot == slot_t'(i))) begin
                r_table[i] <= cfg_owner;
            end
        end
    end

`ifdef TDM_WORK_CONSERVING_EN
    owner_t r_rr_ptr, w_rr_nxt;
    owner_t w_wc_idx, w_cand;
    logic   w_wc_found;

    always_comb begin
        w_wc_found = 1'b0;
        w_wc_idx   = r_rr_ptr;
        w_cand     = r_rr_ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = r_rr_ptr + owner_t'(k);
            if (!w_wc_found && req[w_cand]) begin
                w_wc_found = 1'b1;
                w_wc_idx   = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_rr_ptr <= '0;
        else       r_rr_ptr <= w_rr_nxt;
    end
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_hold_nxt   = r_hold;
        w_winner_nxt = r_winner;
        w_advance    = 1'b0;
`ifdef TDM_WORK_CONSERVING_EN
        w_rr_nxt     = r_rr_ptr;
`endif
        case (r_state)
            IDLE: begin
                if (enable) begin
                    if (req[w_owner]) begin
                        w_state_nxt           = GRANT;
                        w_gnt_nxt             = '0;
                        w_gnt_nxt[w_owner]    = 1'b1;
                        w_hold_nxt            = c_hold_w'(1);
                        w_winner_nxt          = w_owner;
`ifdef TDM_WORK_CONSERVING_EN
                        w_rr_nxt              = w_owner;
                    end else if (w_wc_found) begin
                        // Borrow the idle slot; it advances only after release.
                        w_state_nxt           = GRANT;
                        w_gnt_nxt             = '0;
                        w_gnt_nxt[w_wc_idx]   = 1'b1;
                        w_hold_nxt            = c_hold_w'(1);
                        w_winner_nxt          = w_wc_idx;
                        w_rr_nxt              = w_wc_idx;
`endif
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            GRANT: begin
                if (!req[r_winner] || (r_hold == c_hold_max)) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_hold_nxt  = '0;
                    w_advance   = 1'b1;
                end else begin
                    w_hold_nxt = r_hold + c_hold_w'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_hold   <= '0;
            r_winner <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_hold   <= w_hold_nxt;
            r_winner <= w_winner_nxt;
        end
    end

    tdm_slot_counter #(
        .NUM_SLOTS   (NUM_SLOTS)
    ) u_slot_counter (
        .clk         (clk),
        .reset       (reset),
        .advance     (w_advance),
        .slot        (slot),
        .frame_start (frame_start)
    );

    assign gnt  = r_gnt;
    assign busy = |r_gnt;

endmodule
`default_nettype wire
